// File: rtl/mpram_pkg.sv
// mpram_pkg: shared helpers for the LVT multi-port RAM.
// Port-index width and flat-bus slice extraction.
package mpram_pkg;

  localparam int unsigned BUS_W = 1024;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : int'($clog2(n));
  endfunction

  // Flat buses are zero-extended to BUS_W before slicing.
  function automatic logic [BUS_W-1:0] get_slice(
    input logic [BUS_W-1:0] bus,
    input int unsigned      idx,
    input int unsigned      w
  );
    logic [BUS_W-1:0] m;
    m = (BUS_W'(1) << w) - BUS_W'(1);
    return (bus >> (idx * w)) & m;
  endfunction

  function automatic logic in_range(
    input logic [31:0] a,
    input int unsigned depth
  );
    return a < depth;
  endfunction

endpackage

// File: rtl/mpram_lvt.sv
// mpram_lvt: live-value table, write-port priority and collision flag.
// Lowest enabled port wins a shared address; losers are dropped.
module mpram_lvt
  import mpram_pkg::*;
#(
  parameter int NB_WR      = 2,
  parameter int NB_RD      = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 256,
  parameter int PW         = 1
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic [NB_WR-1:0]                     wren,
  input  logic [NB_WR-1:0][ADDR_WIDTH-1:0]     wa,
  input  logic [NB_RD-1:0][ADDR_WIDTH-1:0]     ra,
  output logic [NB_WR-1:0]                     we,
  output logic [NB_RD-1:0][PW-1:0]             rsel,
  output logic                                 wr_collision
);

  logic [PW-1:0]    lvt [RAM_DEPTH];
  logic [NB_WR-1:0] ok;
  logic             coll;

  always_comb begin
    ok   = '0;
    we   = '0;
    coll = 1'b0;
    for (int i = 0; i < NB_WR; i++)
      ok[i] = wren[i] & in_range(32'(wa[i]), RAM_DEPTH);
    for (int i = 0; i < NB_WR; i++) begin
      we[i] = ok[i] & aresetn;
      for (int k = 0; k < i; k++)
        if (ok[k] && ok[i] && wa[k] == wa[i]) begin
          we[i] = 1'b0;
          coll  = 1'b1;
        end
    end
  end

  always_comb begin
    rsel = '0;
    for (int j = 0; j < NB_RD; j++)
      if (in_range(32'(ra[j]), RAM_DEPTH))
        rsel[j] = lvt[ra[j]];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int a = 0; a < RAM_DEPTH; a++)
        lvt[a] <= '0;
      wr_collision <= 1'b0;
    end else begin
      wr_collision <= coll;
      for (int i = 0; i < NB_WR; i++)
        if (we[i])
          lvt[wa[i]] <= PW'(i);
    end
  end

endmodule

// File: rtl/mpram_nwmr.sv
// mpram_nwmr: NB_WR-write / NB_RD-read RAM built from LVT-steered banks.
// Define MPRAM_BYPASS_EN for write-first reads; default is read-first.
module mpram_nwmr
  import mpram_pkg::*;
#(
  parameter int NB_WR      = 2,
  parameter int NB_RD      = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [NB_WR-1:0]               wren,
  input  logic [NB_WR*ADDR_WIDTH-1:0]    wraddr,
  input  logic [NB_WR*DATA_WIDTH-1:0]    wrdata,
  input  logic [NB_RD-1:0]               rden,
  input  logic [NB_RD*ADDR_WIDTH-1:0]    rdaddr,
  output logic [NB_RD*DATA_WIDTH-1:0]    rddata,
  output logic [NB_RD-1:0]               rdvalid,
  output logic                           wr_collision
);

  localparam int PW = int'(idx_w(NB_WR));

  logic [NB_WR-1:0][ADDR_WIDTH-1:0]             wa;
  logic [NB_WR-1:0][DATA_WIDTH-1:0]             wd;
  logic [NB_RD-1:0][ADDR_WIDTH-1:0]             ra;
  logic [NB_WR-1:0]                             we;
  logic [NB_RD-1:0][PW-1:0]                     rsel;
  logic [NB_WR-1:0][NB_RD-1:0][DATA_WIDTH-1:0]  q;
  logic [NB_RD-1:0][DATA_WIDTH-1:0]             rnext;
  logic [NB_RD-1:0][DATA_WIDTH-1:0]             rq;

  for (genvar i = 0; i < NB_WR; i++) begin : g_wsl
    assign wa[i] = ADDR_WIDTH'(get_slice(BUS_W'(wraddr), i, ADDR_WIDTH));
    assign wd[i] = DATA_WIDTH'(get_slice(BUS_W'(wrdata), i, DATA_WIDTH));
  end

  for (genvar j = 0; j < NB_RD; j++) begin : g_rsl
    assign ra[j] = ADDR_WIDTH'(get_slice(BUS_W'(rdaddr), j, ADDR_WIDTH));
  end

  mpram_lvt #(
    .NB_WR      (NB_WR),
    .NB_RD      (NB_RD),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH),
    .PW         (PW)
  ) u_lvt (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .wren         (wren),
    .wa           (wa),
    .ra           (ra),
    .we           (we),
    .rsel         (rsel),
    .wr_collision (wr_collision)
  );

  // One replica per read port so every bank serves all reads at once.
  for (genvar i = 0; i < NB_WR; i++) begin : g_bank
    for (genvar j = 0; j < NB_RD; j++) begin : g_rep
      logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
      always_ff @(posedge aclk)
        if (we[i])
          mem[wa[i]] <= wd[i];
      assign q[i][j] = mem[ra[j]];
    end
  end

  always_comb begin
    rnext = '0;
    for (int j = 0; j < NB_RD; j++) begin
      if (in_range(32'(ra[j]), RAM_DEPTH)) begin
        rnext[j] = q[rsel[j]][j];
`ifdef MPRAM_BYPASS_EN
        for (int i = 0; i < NB_WR; i++)
          if (we[i] && wa[i] == ra[j])
            rnext[j] = wd[i];
`endif
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rq      <= '0;
      rdvalid <= '0;
    end else begin
      rdvalid <= rden;
      for (int j = 0; j < NB_RD; j++)
        if (rden[j])
          rq[j] <= rnext[j];
    end
  end

  assign rddata = rq;

endmodule

// File: tb/tb_mpram_nwmr.sv
// tb_mpram_nwmr: directed plus random checks of mpram_nwmr against
// a per-bank / last-writer reference model.
module tb_mpram_nwmr;

`ifdef MPRAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic        wen [2];
  logic [7:0]  wad [2];
  logic [31:0] wdt [2];
  logic        ren [2];
  logic [7:0]  rad [2];

  logic [1:0]  wren, rden, rdvalid;
  logic [15:0] wraddr, rdaddr;
  logic [63:0] wrdata, rddata;
  logic        wr_collision;

  assign wren   = {wen[1], wen[0]};
  assign wraddr = {wad[1], wad[0]};
  assign wrdata = {wdt[1], wdt[0]};
  assign rden   = {ren[1], ren[0]};
  assign rdaddr = {rad[1], rad[0]};

  mpram_nwmr dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .wren         (wren),
    .wraddr       (wraddr),
    .wrdata       (wrdata),
    .rden         (rden),
    .rdaddr       (rdaddr),
    .rddata       (rddata),
    .rdvalid      (rdvalid),
    .wr_collision (wr_collision)
  );

  logic [1:0]  w2en = '0, r2en = '0, r2valid;
  logic [15:0] w2addr = '0, r2addr = '0;
  logic [63:0] w2data = '0, r2data;
  logic        c2;

  mpram_nwmr #(.RAM_DEPTH(200)) dut2 (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .wren         (w2en),
    .wraddr       (w2addr),
    .wrdata       (w2data),
    .rden         (r2en),
    .rdaddr       (r2addr),
    .rddata       (r2data),
    .rdvalid      (r2valid),
    .wr_collision (c2)
  );

  logic [31:0] bk  [2][256];
  bit          bkv [2][256];
  int          lvt_m [256];
  logic [31:0] exp_rd [2];
  bit          exp_kn [2];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      wen[i] = 1'b0;
      ren[i] = 1'b0;
    end
  endtask

  task automatic tick();
    bit          claim [256];
    int          win   [256];
    logic [31:0] nd    [256];
    bit          ecoll;
    int          a;
    ecoll = 1'b0;
    for (int i = 0; i < 2; i++)
      if (wen[i]) begin
        if (claim[wad[i]]) ecoll = 1'b1;
        else begin
          claim[wad[i]] = 1'b1;
          win[wad[i]]   = i;
          nd[wad[i]]    = wdt[i];
        end
      end
    for (int j = 0; j < 2; j++)
      if (ren[j]) begin
        a = int'(rad[j]);
        if (BYP && claim[a]) begin
          exp_rd[j] = nd[a];
          exp_kn[j] = 1'b1;
        end else begin
          exp_rd[j] = bk[lvt_m[a]][a];
          exp_kn[j] = bkv[lvt_m[a]][a];
        end
      end
    @(posedge aclk);
    for (int i = 0; i < 2; i++)
      if (wen[i] && win[wad[i]] == i) begin
        bk[i][wad[i]]  = wdt[i];
        bkv[i][wad[i]] = 1'b1;
        lvt_m[wad[i]]  = i;
      end
    #1;
    for (int j = 0; j < 2; j++) begin
      check($sformatf("rdvalid%0d", j), 32'(rdvalid[j]), 32'(ren[j]));
      if (exp_kn[j])
        check($sformatf("rddata%0d", j), rddata[j*32 +: 32], exp_rd[j]);
    end
    check("wr_collision", 32'(wr_collision), 32'(ecoll));
  endtask

  task automatic chk_reset();
    check("rst_rdvalid", 32'(rdvalid), 32'd0);
    check("rst_rddata0", rddata[31:0], 32'd0);
    check("rst_rddata1", rddata[63:32], 32'd0);
    check("rst_coll", 32'(wr_collision), 32'd0);
  endtask

  function automatic logic [7:0] rnd_addr();
    return ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
  endfunction

  initial begin
    idle();
    for (int i = 0; i < 2; i++) begin
      wad[i] = '0; wdt[i] = '0; rad[i] = '0;
      exp_rd[i] = '0; exp_kn[i] = 1'b1;
    end
    #2 chk_reset();
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b1;

    // last-writer 0 at addr 100, read back on port 1
    wen[0] = 1'b1; wad[0] = 8'd100; wdt[0] = 32'h0000BEEF;
    tick();
    idle(); ren[1] = 1'b1; rad[1] = 8'd100;
    tick();
    check("beef_p1", rddata[63:32], 32'h0000BEEF);

    // port 1 then port 0 at addr 34: newest write wins
    idle(); wen[1] = 1'b1; wad[1] = 8'd34; wdt[1] = 32'h1234;
    tick();
    idle(); wen[0] = 1'b1; wad[0] = 8'd34; wdt[0] = 32'h5678;
    tick();
    idle(); ren[0] = 1'b1; rad[0] = 8'd34; ren[1] = 1'b1; rad[1] = 8'd34;
    tick();
    check("a34_p0", rddata[31:0], 32'h5678);
    check("a34_p1", rddata[63:32], 32'h5678);

    // same-edge collision on addr 7
    idle();
    wen[0] = 1'b1; wad[0] = 8'd7; wdt[0] = 32'hAAAA;
    wen[1] = 1'b1; wad[1] = 8'd7; wdt[1] = 32'hBBBB;
    tick();
    check("coll_pulse", 32'(wr_collision), 32'd1);
    idle(); ren[0] = 1'b1; rad[0] = 8'd7;
    tick();
    check("coll_drop", 32'(wr_collision), 32'd0);
    check("coll_win", rddata[31:0], 32'hAAAA);

    // read-during-write at addr 255
    idle(); wen[0] = 1'b1; wad[0] = 8'd255; wdt[0] = 32'h1;
    tick();
    wdt[0] = 32'h2; ren[0] = 1'b1; rad[0] = 8'd255;
    tick();
    check("rdw_255", rddata[31:0], BYP ? 32'h2 : 32'h1);

    // reset mid-operation with a read pending and a write offered
    idle(); ren[0] = 1'b1; rad[0] = 8'd100;
    #2 aresetn = 1'b0;
    #1 chk_reset();
    wen[0] = 1'b1; wad[0] = 8'd100; wdt[0] = 32'hDEAD;
    repeat (2) @(posedge aclk);
    #1 chk_reset();
    #3 aresetn = 1'b1;
    idle();
    for (int a = 0; a < 256; a++) lvt_m[a] = 0;
    for (int j = 0; j < 2; j++) begin
      exp_rd[j] = '0; exp_kn[j] = 1'b1;
    end
    ren[0] = 1'b1; rad[0] = 8'd100;
    tick();
    check("post_rst", rddata[31:0], 32'h0000BEEF);

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        wen[i] = 1'($urandom);
        wad[i] = rnd_addr();
        wdt[i] = $urandom;
        ren[i] = 1'($urandom);
        rad[i] = rnd_addr();
      end
      if ($urandom % 5 == 0) rad[1] = rad[0];
      tick();
    end
    idle();

    // out-of-range handling on a 200-word instance
    w2en = 2'b01; w2addr = 16'd10; w2data = 64'h55;
    @(posedge aclk); #1;
    w2en = 2'b01; w2addr = 16'd210; w2data = 64'hFFFF;
    r2en = 2'b01; r2addr = 16'd210;
    @(posedge aclk); #1;
    check("oor_valid", 32'(r2valid), 32'd1);
    check("oor_data", r2data[31:0], 32'd0);
    check("oor_coll", 32'(c2), 32'd0);
    w2en = 2'b00; r2en = 2'b11; r2addr = {8'd10, 8'd10};
    @(posedge aclk); #1;
    check("oor_keep0", r2data[31:0], 32'h55);
    check("oor_keep1", r2data[63:32], 32'h55);
    r2en = 2'b01; r2addr = 16'd210;
    @(posedge aclk); #1;
    check("oor_again", r2data[31:0], 32'd0);
    r2en = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
